modulo_controlador_reabastecimento_rolhas: RTL and testbench
============================================================

# modulo_controlador_reabastecimento_rolhas

Cork-supply controller for the filling/sealing line. It owns the principal cork dispenser count (feeds the sealing station) and the secondary cork stock (operator-loaded). It accepts operator add/remove requests on the stock through a valid/ready handshake. It runs a refill state machine that moves one cork at a time from stock to dispenser at the feeder's mechanical rate, and decrements the dispenser on each sealing. It replaces ad-hoc buffer counters and drives the display encoders and the sealing FSM's `ro`/minimum flags.

## Interface
Parameters:
- `MAX_PRINCIPAL`, 20: dispenser capacity (corks).
- `LIMIAR_MIN`, 5: refill request threshold; refill is requested when principal ≤ this value.
- `MAX_SECUNDARIO`, 99: stock capacity (display limit).
- `T_TRANSFER`, 4: clock cycles per cork moved; must be ≥1.

Ports:
- `clk`  in  1  system clock (divided clock domain). The block uses this one clock only.
- `clr`  in  1  reset, asynchronous, active-high.
- `enable`  in  1  line running (start_stop); gates refill only.
- `consome`  in  1  single-cycle pulse; one cork used by sealing.
- `load_valid`  in  1  operator stock request.
- `load_op`  in  1  0 = add, 1 = remove.
- `load_value`  in  7  request amount, 0..127.
- `load_ready`  out  1  high only in IDLE.
- `load_err`  out  1  one-cycle pulse on a rejected request.
- `reg_principal`  out  5  dispenser count.
- `reg_secundario`  out  7  stock count.
- `ro`  out  1  principal == 0.
- `min_signal`  out  1  principal ≤ LIMIAR_MIN.
- `alimentando`  out  1  state == FEED.

## Operation
- Reset values: state IDLE, timer 0, `reg_principal` 0, `reg_secundario` 0, `load_err` 0, `load_ready` 1, `alimentando` 0, `ro` 1, `min_signal` 1.
- `ro`, `min_signal`, `load_ready` and `alimentando` are combinational from the registers and state.

IDLE:
- A handshake occurs when `load_valid & load_ready`.
  - Add: accept if stock+value ≤ MAX_SECUNDARIO. Compute with an 8-bit sum so there is no wrap.
  - Remove: accept if value ≤ stock.
  - An accepted request updates the stock at the next edge.
  - A rejected request leaves the stock unchanged and pulses `load_err` for the next cycle.
  - Value 0 is accepted with no change.
- Refill start condition: `enable & min_signal & (stock>0)`.
  - If there is no handshake this cycle, the condition moves the state to FEED with timer = T_TRANSFER−1.
  - A handshake has priority; refill is evaluated the following cycle.

FEED:
- The timer decrements each cycle.
- At timer == 0, one cork moves: principal+1, stock−1, and the timer reloads to T_TRANSFER−1.
- After a move, the state returns to IDLE if principal == MAX_PRINCIPAL or stock == 0.
- `enable` low in FEED: return to IDLE at the next edge with no move (abort; any partial timer is discarded).
- `load_valid` in FEED is not accepted; it is held off by `load_ready` = 0.

Consumption (any state):
- `consome` with principal > 0 decrements principal.
- `consome` with principal == 0 is ignored.
- If a consume and a move occur in the same cycle, principal is unchanged and stock still decrements.
- Principal never exceeds MAX_PRINCIPAL and never wraps below 0.

## Timing
- Handshake to count update: 1 cycle. `load_err` is asserted in the cycle after the request.
- Condition true in IDLE at cycle n: FEED at n+1; first move at the edge ending cycle n+T_TRANSFER.
- Subsequent moves follow every T_TRANSFER cycles.
- Refill from principal p to MAX (sufficient stock): exactly (MAX−p)·T_TRANSFER cycles in FEED.
- `clr` mid-FEED: all registers return to reset values immediately, asynchronously. There is no pending move after release.
- `consome` is sampled every edge; back-to-back pulses each decrement.

## Test plan
- Load, reject and refill: reset, `enable`=0, add 30.
  - Required: stock 30, principal 0, `ro`=1.
  - Then add 70 → `load_err` pulse, stock stays 30.
  - Then remove 31 → `load_err` pulse.
  - Then remove 10 → stock 20.
- Refill cadence: stock 30, principal 0, `enable`=1, T_TRANSFER=4.
  - Required: FEED for 80 cycles, a principal increment every 4 cycles, end at principal 20, stock 10, IDLE.
- Stock exhaustion: stock 3, principal 2, `enable`=1.
  - Required: principal 5, stock 0, return to IDLE after 12 FEED cycles.
  - Required: no restart while stock is 0.
- Simultaneous consume and move: in FEED with principal 10, pulse `consome` on a move edge.
  - Required: principal stays 10, stock −1.
  - Then `consome` at principal 0 → principal remains 0.
- Handshake blocking and abort: `load_valid` during FEED is held with `load_ready`=0 and accepted 1 cycle after IDLE is re-entered.
  - Drop `enable` mid-timer → IDLE next edge, no move.
- Asynchronous reset: assert `clr` between edges during FEED.
  - Required: outputs at reset values before the next edge; `load_ready`=1 after release.

Source files
------------

// File: rtl/modulo_controlador_reabastecimento_rolhas_if.sv
// Operator stock-request channel: valid/ready handshake plus a rejection pulse.
interface modulo_controlador_reabastecimento_rolhas_if;
  logic       load_valid;
  logic       load_op;
  logic [6:0] load_value;
  logic       load_ready;
  logic       load_err;

  modport master (
    output load_valid,
    output load_op,
    output load_value,
    input  load_ready,
    input  load_err
  );

  modport slave (
    input  load_valid,
    input  load_op,
    input  load_value,
    output load_ready,
    output load_err
  );
endinterface

// File: rtl/modulo_controlador_reabastecimento_rolhas.sv
// Cork-supply controller: dispenser/stock counters, operator stock requests and a
// timed refill FSM moving one cork per T_TRANSFER cycles from stock to dispenser.
module modulo_controlador_reabastecimento_rolhas #(
  parameter int MAX_PRINCIPAL  = 20,
  parameter int LIMIAR_MIN     = 5,
  parameter int MAX_SECUNDARIO = 99,
  parameter int T_TRANSFER     = 4
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       enable,
  input  logic       consome,
  modulo_controlador_reabastecimento_rolhas_if.slave bus,
  output logic [4:0] reg_principal,
  output logic [6:0] reg_secundario,
  output logic       ro,
  output logic       min_signal,
  output logic       alimentando
);

  localparam int TW = (T_TRANSFER > 1) ? $clog2(T_TRANSFER) : 1;
  localparam logic [4:0]    MAX_P  = 5'(MAX_PRINCIPAL);
  localparam logic [4:0]    LIM_P  = 5'(LIMIAR_MIN);
  localparam logic [7:0]    MAX_S  = 8'(MAX_SECUNDARIO);
  localparam logic [TW-1:0] T_LOAD = TW'(T_TRANSFER - 1);

  typedef enum logic {IDLE, FEED} state_t;

  state_t        state_q;
  logic [TW-1:0] timer_q;
  logic [4:0]    principal_q, principal_d;
  logic [6:0]    secundario_q, secundario_d;
  logic          err_q;

  logic       handshake, accept, start, move, cons;
  logic [7:0] sum8;

  assign reg_principal  = principal_q;
  assign reg_secundario = secundario_q;
  assign ro             = (principal_q == 5'd0);
  assign min_signal     = (principal_q <= LIM_P);
  assign alimentando    = (state_q == FEED);
  assign bus.load_ready = (state_q == IDLE);
  assign bus.load_err   = err_q;

  // 8-bit sum keeps an oversized add from wrapping into an apparently legal value
  assign sum8      = {1'b0, secundario_q} + {1'b0, bus.load_value};
  assign handshake = bus.load_valid & bus.load_ready;
  assign accept    = handshake & (bus.load_op ? (bus.load_value <= secundario_q)
                                              : (sum8 <= MAX_S));
  assign start     = enable & min_signal & (secundario_q != 7'd0);
  assign move      = (state_q == FEED) & enable & (timer_q == '0) & (secundario_q != 7'd0);
  assign cons      = consome & (principal_q != 5'd0);

  always_comb begin
    principal_d = principal_q;
    if (move && !cons)
      principal_d = principal_q + 5'd1;
    else if (cons && !move)
      principal_d = principal_q - 5'd1;

    secundario_d = secundario_q;
    if (move)
      secundario_d = secundario_q - 7'd1;
    else if (accept)
      secundario_d = bus.load_op ? (secundario_q - bus.load_value) : sum8[6:0];
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q      <= IDLE;
      timer_q      <= '0;
      principal_q  <= 5'd0;
      secundario_q <= 7'd0;
      err_q        <= 1'b0;
    end else begin
      principal_q  <= principal_d;
      secundario_q <= secundario_d;
      err_q        <= handshake & ~accept;
      case (state_q)
        IDLE: begin
          // An operator request wins; refill is re-evaluated on the following cycle
          if (!handshake && start) begin
            state_q <= FEED;
            timer_q <= T_LOAD;
          end
        end
        FEED: begin
          if (!enable) begin
            state_q <= IDLE;
            timer_q <= '0;
          end else if (timer_q == '0) begin
            timer_q <= T_LOAD;
            if (principal_d == MAX_P || secundario_d == 7'd0) begin
              state_q <= IDLE;
              timer_q <= '0;
            end
          end else begin
            timer_q <= timer_q - 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          timer_q <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_modulo_controlador_reabastecimento_rolhas.sv
// Directed bench for the cork-supply controller with hand-computed expectations.
module tb_modulo_controlador_reabastecimento_rolhas;

  logic clk;
  logic clr;
  logic enable;
  logic consome;
  logic [4:0] reg_principal;
  logic [6:0] reg_secundario;
  logic ro, min_signal, alimentando;

  int checks = 0;
  int errors = 0;
  int cnt;

  modulo_controlador_reabastecimento_rolhas_if bus();

  modulo_controlador_reabastecimento_rolhas dut (
    .clk            (clk),
    .clr            (clr),
    .enable         (enable),
    .consome        (consome),
    .bus            (bus.slave),
    .reg_principal  (reg_principal),
    .reg_secundario (reg_secundario),
    .ro             (ro),
    .min_signal     (min_signal),
    .alimentando    (alimentando)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_val(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic op, input int value);
    bus.load_valid = 1'b1;
    bus.load_op    = op;
    bus.load_value = 7'(value);
    tick();
    bus.load_valid = 1'b0;
  endtask

  initial begin
    clr            = 1'b1;
    enable         = 1'b0;
    consome        = 1'b0;
    bus.load_valid = 1'b0;
    bus.load_op    = 1'b0;
    bus.load_value = 7'd0;
    #12;
    check_val("rst_principal", reg_principal, 0);
    check_val("rst_secundario", reg_secundario, 0);
    check_val("rst_ro", ro, 1);
    check_val("rst_min", min_signal, 1);
    check_val("rst_ready", bus.load_ready, 1);
    check_val("rst_alim", alimentando, 0);
    check_val("rst_err", bus.load_err, 0);
    @(negedge clk);
    clr = 1'b0;
    tick();

    // Load, reject, remove
    load(1'b0, 30);
    check_val("add30_sec", reg_secundario, 30);
    check_val("add30_pri", reg_principal, 0);
    check_val("add30_ro", ro, 1);
    check_val("add30_err", bus.load_err, 0);
    load(1'b0, 70);
    check_val("add70_err", bus.load_err, 1);
    check_val("add70_sec", reg_secundario, 30);
    tick();
    check_val("err_clears", bus.load_err, 0);
    load(1'b1, 31);
    check_val("rem31_err", bus.load_err, 1);
    check_val("rem31_sec", reg_secundario, 30);
    load(1'b1, 10);
    check_val("rem10_err", bus.load_err, 0);
    check_val("rem10_sec", reg_secundario, 20);
    load(1'b0, 0);
    check_val("add0_err", bus.load_err, 0);
    check_val("add0_sec", reg_secundario, 20);
    load(1'b0, 10);
    check_val("add10_sec", reg_secundario, 30);

    // Refill cadence: 0 -> 20 over 80 FEED cycles
    enable = 1'b1;
    tick();
    cnt = 0;
    while (alimentando && cnt < 200) begin
      cnt++;
      if (cnt == 4)  check_val("feed_j4_pri", reg_principal, 0);
      if (cnt == 5)  check_val("feed_j5_pri", reg_principal, 1);
      if (cnt == 80) check_val("feed_j80_pri", reg_principal, 19);
      tick();
    end
    check_val("feed_cycles", cnt, 80);
    check_val("feed_end_pri", reg_principal, 20);
    check_val("feed_end_sec", reg_secundario, 10);
    check_val("feed_end_idle", alimentando, 0);
    check_val("feed_end_min", min_signal, 0);

    // Stock exhaustion: principal 2, stock 3
    enable  = 1'b0;
    consome = 1'b1;
    repeat (18) tick();
    consome = 1'b0;
    check_val("cons18_pri", reg_principal, 2);
    load(1'b1, 7);
    check_val("rem7_sec", reg_secundario, 3);
    enable = 1'b1;
    tick();
    cnt = 0;
    while (alimentando && cnt < 200) begin
      cnt++;
      tick();
    end
    check_val("exh_cycles", cnt, 12);
    check_val("exh_pri", reg_principal, 5);
    check_val("exh_sec", reg_secundario, 0);
    repeat (10) tick();
    check_val("exh_no_restart", alimentando, 0);

    // Consume coinciding with a move
    enable = 1'b0;
    load(1'b0, 50);
    check_val("add50_sec", reg_secundario, 50);
    enable = 1'b1;
    tick();
    repeat (23) tick();
    check_val("pre_coinc_pri", reg_principal, 10);
    check_val("pre_coinc_sec", reg_secundario, 45);
    consome = 1'b1;
    tick();
    consome = 1'b0;
    check_val("coinc_pri", reg_principal, 10);
    check_val("coinc_sec", reg_secundario, 44);
    enable = 1'b0;
    tick();
    check_val("abort1_idle", alimentando, 0);
    consome = 1'b1;
    repeat (10) tick();
    check_val("drain_pri", reg_principal, 0);
    tick();
    consome = 1'b0;
    check_val("cons_at0_pri", reg_principal, 0);
    check_val("cons_at0_ro", ro, 1);

    // Handshake held off in FEED, abort mid-timer
    enable = 1'b1;
    tick();
    tick();
    bus.load_valid = 1'b1;
    bus.load_op    = 1'b0;
    bus.load_value = 7'd1;
    #1;
    check_val("feed_ready", bus.load_ready, 0);
    tick();
    check_val("held_sec", reg_secundario, 44);
    enable = 1'b0;
    tick();
    check_val("abort_idle", alimentando, 0);
    check_val("abort_pri", reg_principal, 0);
    check_val("abort_sec", reg_secundario, 44);
    check_val("abort_ready", bus.load_ready, 1);
    tick();
    bus.load_valid = 1'b0;
    check_val("late_accept_sec", reg_secundario, 45);

    // Asynchronous reset during FEED
    enable = 1'b1;
    tick();
    repeat (5) tick();
    check_val("pre_clr_pri", reg_principal, 1);
    check_val("pre_clr_alim", alimentando, 1);
    #2;
    clr = 1'b1;
    #1;
    check_val("clr_pri", reg_principal, 0);
    check_val("clr_sec", reg_secundario, 0);
    check_val("clr_alim", alimentando, 0);
    check_val("clr_ro", ro, 1);
    check_val("clr_ready", bus.load_ready, 1);
    @(negedge clk);
    clr = 1'b0;
    tick();
    check_val("post_clr_ready", bus.load_ready, 1);
    check_val("post_clr_alim", alimentando, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
